layered_rgb_mux: RTL and testbench

Parametrised priority mux that merges any number of object drawing layers with the background into the single VGA RGB stream. It replaces the fixed-layer object mux. Lowest layer index wins; layers can be masked at runtime. The block adds a two-stage pipeline, a per-frame collision detector for layer 0 (the player), and a blink/blank display-mode FSM driven by frame boundaries.

---
 rtl/layered_rgb_mux.sv | 168 ++++++++++++++++
 tb/tb_layered_rgb_mux.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layered_rgb_mux.sv
// Priority mux of NUM_LAYERS drawing layers over the background (index 0 wins),
// with a two-stage pixel pipeline, per-frame player collision pulse and flash/blank modes.
module layered_rgb_mux #(
   parameter int NUM_LAYERS = 24,
   parameter int RGB_W = 8,
   parameter int FLASH_FRAMES = 8,
   parameter logic [RGB_W-1:0] FLASH_RGB = 8'hFF
) (
   input  logic                             clk,
   input  logic                             resetN,
   input  logic [NUM_LAYERS-1:0]            layerDR,
   input  logic [NUM_LAYERS-1:0][RGB_W-1:0] layerRGB,
   input  logic [RGB_W-1:0]                 backGroundRGB,
   input  logic [NUM_LAYERS-1:0]            layerEnable,
   input  logic                             startOfFrame,
   input  logic                             timeout,
   input  logic                             flashReq,
   output logic [RGB_W-1:0]                 RGBOut,
   output logic                             collision,
   output logic                             flashing,
   output logic [1:0]                       stateDbg
);

   localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
   localparam int CNT_W = $clog2(FLASH_FRAMES + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLASH_FRAMES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      NORMAL = 2'd0,
      FLASH  = 2'd1,
      BLANK  = 2'd2
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;

   logic [NUM_LAYERS-1:0] eff;
   logic                  win_valid_d;
   logic [IDX_W-1:0]      win_idx_d;
   logic [RGB_W-1:0]      win_rgb_d;
   logic                  ovl_d;

   logic                  s1_valid;
   logic [IDX_W-1:0]      s1_idx;
   logic [RGB_W-1:0]      s1_rgb;
   logic                  s1_ovl;

   logic                  hitSeen;
   logic                  hit_eff;

   assign eff         = layerDR & layerEnable;
   assign win_valid_d = |eff;

   // Scan from the top down so the lowest requesting index is the last one written.
   always_comb begin
      win_idx_d = '0;
      win_rgb_d = backGroundRGB;
      for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
         if (eff[i]) begin
            win_idx_d = IDX_W'(i);
            win_rgb_d = layerRGB[i];
         end
      end
   end

   generate
      if (NUM_LAYERS > 1) begin : g_ovl
         assign ovl_d = eff[0] & (|eff[NUM_LAYERS-1:1]);
      end else begin : g_no_ovl
         assign ovl_d = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         s1_valid <= 1'b0;
         s1_idx   <= '0;
         s1_rgb   <= '0;
         s1_ovl   <= 1'b0;
      end else begin
         s1_valid <= win_valid_d;
         s1_idx   <= win_idx_d;
         s1_rgb   <= win_rgb_d;
         s1_ovl   <= ovl_d;
      end
   end

   // Display-mode FSM; timeout overrides everything and clears the flash counter.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state    <= NORMAL;
         cnt      <= '0;
         flashing <= 1'b0;
      end else if (timeout) begin
         state    <= BLANK;
         cnt      <= '0;
         flashing <= 1'b0;
      end else begin
         unique case (state)
            NORMAL: begin
               if (flashReq) begin
                  state    <= FLASH;
                  cnt      <= CNT_LOAD;
                  flashing <= 1'b1;
               end else begin
                  flashing <= 1'b0;
               end
            end
            FLASH: begin
               if (flashReq) begin
                  cnt      <= CNT_LOAD;
                  flashing <= 1'b1;
               end else if (startOfFrame && cnt == CNT_ONE) begin
                  state    <= NORMAL;
                  cnt      <= '0;
                  flashing <= 1'b0;
               end else if (startOfFrame) begin
                  cnt      <= cnt - CNT_ONE;
                  flashing <= 1'b1;
               end else begin
                  flashing <= 1'b1;
               end
            end
            BLANK: begin
               state    <= NORMAL;
               flashing <= 1'b0;
            end
            default: begin
               state    <= NORMAL;
               cnt      <= '0;
               flashing <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         RGBOut <= '0;
      end else if (state == BLANK || timeout) begin
         RGBOut <= backGroundRGB;
      end else if (state == FLASH && cnt[0] && s1_valid && s1_idx == '0) begin
         RGBOut <= FLASH_RGB;
      end else begin
         RGBOut <= s1_rgb;
      end
   end

   // A frame start clears the seen flag before this cycle's overlap is judged.
   assign hit_eff = startOfFrame ? 1'b0 : hitSeen;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         collision <= 1'b0;
         hitSeen   <= 1'b0;
      end else if (s1_ovl && !hit_eff && state != BLANK) begin
         collision <= 1'b1;
         hitSeen   <= 1'b1;
      end else begin
         collision <= 1'b0;
         hitSeen   <= hit_eff;
      end
   end

   assign stateDbg = state;

endmodule

// File: tb/tb_layered_rgb_mux.sv
// Bench for layered_rgb_mux: directed priority/latency/collision/flash/timeout
// scenarios followed by randomized traffic, all checked against a behavioural model.
module tb_layered_rgb_mux;

   localparam int NL = 8;
   localparam int W  = 8;
   localparam int FF = 4;
   localparam logic [W-1:0] FRGB = 8'hFF;

   localparam int M_NORMAL = 0;
   localparam int M_FLASH  = 1;
   localparam int M_BLANK  = 2;

   logic                  clk = 1'b0;
   logic                  resetN;
   logic [NL-1:0]         layerDR;
   logic [NL-1:0][W-1:0]  layerRGB;
   logic [W-1:0]          backGroundRGB;
   logic [NL-1:0]         layerEnable;
   logic                  startOfFrame;
   logic                  timeout;
   logic                  flashReq;
   logic [W-1:0]          RGBOut;
   logic                  collision;
   logic                  flashing;
   logic [1:0]            stateDbg;

   logic [W-1:0]          rgb_single;
   logic                  col_single;
   logic                  flash_single;
   logic [1:0]            state_single;

   layered_rgb_mux #(.NUM_LAYERS(NL), .RGB_W(W), .FLASH_FRAMES(FF), .FLASH_RGB(FRGB)) dut (
      .clk(clk), .resetN(resetN), .layerDR(layerDR), .layerRGB(layerRGB),
      .backGroundRGB(backGroundRGB), .layerEnable(layerEnable),
      .startOfFrame(startOfFrame), .timeout(timeout), .flashReq(flashReq),
      .RGBOut(RGBOut), .collision(collision), .flashing(flashing), .stateDbg(stateDbg)
   );

   layered_rgb_mux #(.NUM_LAYERS(1), .RGB_W(W), .FLASH_FRAMES(FF), .FLASH_RGB(FRGB)) dut_single (
      .clk(clk), .resetN(resetN), .layerDR(layerDR[0]), .layerRGB(layerRGB[0]),
      .backGroundRGB(backGroundRGB), .layerEnable(layerEnable[0]),
      .startOfFrame(startOfFrame), .timeout(timeout), .flashReq(flashReq),
      .RGBOut(rgb_single), .collision(col_single), .flashing(flash_single),
      .stateDbg(state_single)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not end in time");
      $fatal(1);
   end

   int checks = 0;
   int errors = 0;
   int col_cnt = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // behavioural reference model
   logic [W-1:0] exp_q[$];
   bit           m_s1_valid;
   int           m_s1_idx;
   logic [W-1:0] m_s1_rgb;
   bit           m_s1_ovl;
   int           m_state;
   int           m_cnt;
   bit           m_hit;
   bit           exp_col;
   bit           exp_flash;

   task automatic model_reset();
      m_s1_valid = 0; m_s1_idx = 0; m_s1_rgb = '0; m_s1_ovl = 0;
      m_state = M_NORMAL; m_cnt = 0; m_hit = 0;
      exp_col = 0; exp_flash = 0;
      exp_q.delete();
   endtask

   task automatic model_step();
      logic [W-1:0] px;
      bit hit_eff;
      int winner;
      int others;
      if (m_state == M_BLANK || timeout) px = backGroundRGB;
      else if (m_state == M_FLASH && (m_cnt % 2) == 1 && m_s1_valid && m_s1_idx == 0) px = FRGB;
      else px = m_s1_rgb;
      exp_q.push_back(px);

      hit_eff = startOfFrame ? 1'b0 : m_hit;
      if (m_s1_ovl && !hit_eff && m_state != M_BLANK) begin
         exp_col = 1; m_hit = 1;
      end else begin
         exp_col = 0; m_hit = hit_eff;
      end

      if (timeout) begin
         m_state = M_BLANK; m_cnt = 0;
      end else if (m_state == M_NORMAL) begin
         if (flashReq) begin m_state = M_FLASH; m_cnt = FF; end
      end else if (m_state == M_FLASH) begin
         if (flashReq) m_cnt = FF;
         else if (startOfFrame) begin
            if (m_cnt == 1) begin m_state = M_NORMAL; m_cnt = 0; end
            else m_cnt = m_cnt - 1;
         end
      end else begin
         m_state = M_NORMAL;
      end
      exp_flash = (m_state == M_FLASH);

      winner = -1;
      others = 0;
      for (int i = NL - 1; i >= 0; i--) begin
         if (layerDR[i] && layerEnable[i]) begin
            winner = i;
            if (i > 0) others++;
         end
      end
      m_s1_valid = (winner >= 0);
      m_s1_idx   = winner;
      m_s1_rgb   = (winner >= 0) ? layerRGB[winner] : backGroundRGB;
      m_s1_ovl   = layerDR[0] && layerEnable[0] && (others > 0);
   endtask

   // driver: one pixel cycle, then scoreboard compare on the falling edge
   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_val("rgb", RGBOut, exp_q.pop_front());
      check_val("collision", collision, exp_col);
      check_val("flashing", flashing, exp_flash);
      check_val("single_collision", col_single, 1'b0);
      if (collision) col_cnt++;
   endtask

   task automatic pulse_sof();
      startOfFrame = 1'b1;
      cycle();
      startOfFrame = 1'b0;
   endtask

   task automatic pulse_flash();
      flashReq = 1'b1;
      cycle();
      flashReq = 1'b0;
   endtask

   initial begin
      int to_left;
      resetN = 1'b0;
      layerDR = '0; layerRGB = '0; backGroundRGB = '0; layerEnable = '0;
      startOfFrame = 1'b0; timeout = 1'b0; flashReq = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_val("reset_rgb", RGBOut, 8'h00);
      check_val("reset_collision", collision, 1'b0);
      check_val("reset_flashing", flashing, 1'b0);
      resetN = 1'b1;

      // priority and mask
      layerEnable = '1;
      backGroundRGB = 8'h25;
      for (int i = 0; i < NL; i++) layerRGB[i] = W'($urandom);
      layerRGB[1] = 8'h1C;
      layerRGB[2] = 8'hE0;
      layerDR = 8'b0000_0110;
      repeat (2) cycle();
      check_val("prio", RGBOut, 8'h1C);
      layerEnable[1] = 1'b0;
      repeat (2) cycle();
      check_val("mask", RGBOut, 8'hE0);
      layerDR = '0;
      repeat (2) cycle();
      check_val("background", RGBOut, 8'h25);
      layerEnable = '1;

      // latency stream then asynchronous reset mid-stream
      layerDR = 8'b0000_1000;
      for (int i = 0; i < 20; i++) begin
         layerRGB[3] = W'(8'h40 + i);
         cycle();
      end
      #2 resetN = 1'b0;
      #1;
      check_val("async_reset_rgb", RGBOut, 8'h00);
      check_val("async_reset_flashing", flashing, 1'b0);
      model_reset();
      @(negedge clk);
      resetN = 1'b1;

      // collision: three overlaps in one frame, one in the next, none when masked
      layerRGB[0] = 8'h33;
      layerDR = '0;
      pulse_sof();
      col_cnt = 0;
      for (int k = 0; k < 3; k++) begin
         layerDR = 8'b0010_0001; cycle();
         layerDR = '0; repeat (2) cycle();
      end
      repeat (2) cycle();
      check_val("collision_frame1", col_cnt, 1);
      pulse_sof();
      col_cnt = 0;
      layerDR = 8'b0010_0001; cycle();
      layerDR = '0; repeat (3) cycle();
      check_val("collision_frame2", col_cnt, 1);
      layerEnable[5] = 1'b0;
      pulse_sof();
      col_cnt = 0;
      layerDR = 8'b0010_0001; repeat (2) cycle();
      layerDR = '0; repeat (3) cycle();
      check_val("collision_masked", col_cnt, 0);
      layerEnable = '1;

      // flash over four frames
      layerDR = 8'b0000_0001;
      pulse_flash();
      for (int f = 0; f < 5; f++) begin
         repeat (3) cycle();
         check_val("flash_pixel", RGBOut, (f == 1 || f == 3) ? FRGB : 8'h33);
         check_val("flash_active", flashing, (f < 4) ? 1'b1 : 1'b0);
         pulse_sof();
      end

      // reload on the last flash frame
      pulse_flash();
      repeat (3) begin
         repeat (2) cycle();
         pulse_sof();
      end
      flashReq = 1'b1; startOfFrame = 1'b1;
      cycle();
      flashReq = 1'b0; startOfFrame = 1'b0;
      check_val("reload", flashing, 1'b1);
      repeat (2) cycle();
      pulse_sof();
      check_val("reload_hold", flashing, 1'b1);

      // timeout during flash: background only, no collisions, flashReq ignored
      layerDR = 8'b0010_0001;
      timeout = 1'b1;
      col_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         startOfFrame = (i == 4);
         flashReq = (i == 6);
         cycle();
         startOfFrame = 1'b0;
         flashReq = 1'b0;
         if (i == 0) col_cnt = 0;
         else begin
            check_val("blank_rgb", RGBOut, 8'h25);
            check_val("blank_flashing", flashing, 1'b0);
         end
      end
      check_val("blank_collision", col_cnt, 0);
      timeout = 1'b0;
      repeat (2) cycle();
      check_val("unblank_rgb", RGBOut, 8'h33);
      check_val("unblank_flashing", flashing, 1'b0);

      // randomized traffic
      to_left = 0;
      for (int n = 0; n < 3000; n++) begin
         layerDR = NL'($urandom & $urandom);
         layerEnable = NL'(~($urandom & $urandom & $urandom));
         for (int i = 0; i < NL; i++) layerRGB[i] = W'($urandom);
         if ($urandom_range(0, 15) == 0) backGroundRGB = W'($urandom);
         startOfFrame = ($urandom_range(0, 39) == 0);
         flashReq = ($urandom_range(0, 59) == 0);
         if (to_left > 0) begin
            timeout = 1'b1;
            to_left--;
         end else begin
            timeout = 1'b0;
            if ($urandom_range(0, 199) == 0) to_left = $urandom_range(1, 20);
         end
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
